// File: rtl/array_bus_merge.sv
// array_bus_merge
//   Merges a 2-lane array bus into a single ready/valid stream. Each lane has its own
//   DEPTH-entry FIFO with no backpressure to the source. Words arriving while a lane's FIFO
//   is full are dropped and flagged. A one-entry registered output stage is refilled from
//   the FIFOs by a round-robin arbiter.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   in_data    per-lane input data            [0:1] x DATA_WIDTH
//   in_valid   per-lane input valid           [0:1]
//   out_data   merged stream data (registered)
//   out_lane   source lane of out_data (registered)
//   out_valid  merged stream valid (registered)
//   out_ready  sink ready; transfer when out_valid && out_ready
//   overflow   sticky per-lane drop flag      [0:1]

module array_bus_merge #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data   [0:1],
  input  logic                  in_valid  [0:1],
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_lane,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow  [0:1]
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  // Per-lane FIFO storage and bookkeeping.
  logic [DATA_WIDTH-1:0] mem_q    [0:1][0:DEPTH-1];
  logic [PtrW-1:0]       wr_ptr_q [0:1];
  logic [PtrW-1:0]       rd_ptr_q [0:1];
  logic [CntW-1:0]       count_q  [0:1];
  logic [CntW-1:0]       count_d  [0:1];
  logic                  ovf_q    [0:1];

  // Output stage and arbiter state.
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_lane_q;
  logic                  out_valid_q;
  logic                  last_grant_q;

  logic empty [0:1];
  logic full  [0:1];
  logic push  [0:1];
  logic pop   [0:1];
  logic drop  [0:1];
  logic load;
  logic grant;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      empty[i] = (count_q[i] == '0);
      full[i]  = (count_q[i] == DepthCnt);
    end

    // Refill when the stage is empty or draining this cycle; occupancy is pre-push.
    load = (!out_valid_q || out_ready) && (!empty[0] || !empty[1]);

    // On a tie, favour the lane not granted last; otherwise take the non-empty lane.
    if (!empty[0] && !empty[1]) begin
      grant = ~last_grant_q;
    end else begin
      grant = empty[0];
    end

    pop[0] = load && !grant;
    pop[1] = load && grant;

    for (int i = 0; i < 2; i++) begin
      // Fullness is judged before this edge's pop, so a full lane drops even while popping.
      push[i]    = in_valid[i] && !full[i];
      drop[i]    = in_valid[i] && full[i];
      count_d[i] = count_q[i] + CntW'(push[i]) - CntW'(pop[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
        ovf_q[i]    <= 1'b0;
      end
      out_data_q   <= '0;
      out_lane_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          mem_q[i][wr_ptr_q[i]] <= in_data[i];
          wr_ptr_q[i]           <= wr_ptr_q[i] + 1'b1;
        end
        if (pop[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        end
        count_q[i] <= count_d[i];
        if (drop[i]) begin
          ovf_q[i] <= 1'b1;
        end
      end

      if (load) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= mem_q[grant][rd_ptr_q[grant]];
        out_lane_q   <= grant;
        last_grant_q <= grant;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data    = out_data_q;
  assign out_lane    = out_lane_q;
  assign out_valid   = out_valid_q;
  assign overflow[0] = ovf_q[0];
  assign overflow[1] = ovf_q[1];

endmodule

// File: tb/tb_array_bus_merge.sv
// Directed bench for array_bus_merge (DATA_WIDTH=8, DEPTH=4). Inputs are driven 1ns after a
// rising edge and outputs are sampled at the same point, so "cycle n" is the interval after
// the n-th edge following the cycle in which a stimulus was first applied.

module tb_array_bus_merge;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data  [0:1];
  logic          in_valid [0:1];
  logic [DW-1:0] out_data;
  logic          out_lane;
  logic          out_valid;
  logic          out_ready;
  logic          overflow [0:1];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  array_bus_merge #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_lane (out_lane),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow (overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v0, input logic [DW-1:0] d0,
                        input logic v1, input logic [DW-1:0] d1);
    in_valid[0] = v0;
    in_data[0]  = d0;
    in_valid[1] = v1;
    in_data[1]  = d1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [DW-1:0] data, input logic lane);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_data"},  32'(out_data),  32'(data));
    check_eq({tag, "_lane"},  32'(out_lane),  32'(lane));
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    set_in(1'b0, 8'h00, 1'b0, 8'h00);
    step();
    step();
    rst = 1'b0;

    // Reset state.
    check_eq("rst_valid", 32'(out_valid),   32'd0);
    check_eq("rst_data",  32'(out_data),    32'd0);
    check_eq("rst_lane",  32'(out_lane),    32'd0);
    check_eq("rst_ovf0",  32'(overflow[0]), 32'd0);
    check_eq("rst_ovf1",  32'(overflow[1]), 32'd0);

    // Single word: valid appears in cycle 2, gone in cycle 3.
    out_ready = 1'b1;
    set_in(1'b1, 8'hA5, 1'b0, 8'h00);
    step();
    check_eq("single_c1_valid", 32'(out_valid), 32'd0);
    set_in(1'b0, 8'h00, 1'b0, 8'h00);
    step();
    expect_out("single_c2", 8'hA5, 1'b0);
    step();
    check_eq("single_c3_valid", 32'(out_valid), 32'd0);

    // Ties: fresh reset so lane 0 wins first; the second tie decision then favours lane 1.
    do_reset();
    out_ready = 1'b1;
    set_in(1'b1, 8'h11, 1'b1, 8'h22);
    step();
    set_in(1'b1, 8'h33, 1'b1, 8'h44);
    step();
    set_in(1'b0, 8'h00, 1'b0, 8'h00);
    expect_out("tie_0", 8'h11, 1'b0);
    step();
    expect_out("tie_1", 8'h22, 1'b1);
    step();
    expect_out("tie_2", 8'h33, 1'b0);
    step();
    expect_out("tie_3", 8'h44, 1'b1);
    step();
    check_eq("tie_end_valid", 32'(out_valid), 32'd0);

    // Stall on lane 1, then release.
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      set_in(1'b0, 8'h00, 1'b1, 8'(i));
      step();
    end
    set_in(1'b0, 8'h00, 1'b0, 8'h00);
    step();
    step();
    expect_out("stall_hold", 8'h01, 1'b1);
    out_ready = 1'b1;
    expect_out("stall_d0", 8'h01, 1'b1);
    step();
    expect_out("stall_d1", 8'h02, 1'b1);
    step();
    expect_out("stall_d2", 8'h03, 1'b1);
    step();
    check_eq("stall_end_valid", 32'(out_valid), 32'd0);

    // Overflow: 7 words into a stalled lane 0; 05 and 06 are dropped.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_in(1'b1, 8'(i), 1'b0, 8'h00);
      step();
      if (i == 4) check_eq("ovf_not_yet", 32'(overflow[0]), 32'd0);
    end
    set_in(1'b0, 8'h00, 1'b0, 8'h00);
    check_eq("ovf_lane0", 32'(overflow[0]), 32'd1);
    check_eq("ovf_lane1", 32'(overflow[1]), 32'd0);
    expect_out("ovf_hold", 8'h00, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      expect_out($sformatf("ovf_drain%0d", k), 8'(k), 1'b0);
      step();
    end
    check_eq("ovf_end_valid",  32'(out_valid),   32'd0);
    check_eq("ovf_sticky",     32'(overflow[0]), 32'd1);

    // Full FIFO popped on the same edge as a new arrival: the arrival is dropped.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 8'(8'h10 + i), 1'b0, 8'h00);
      step();
    end
    check_eq("fpop_pre_ovf", 32'(overflow[0]), 32'd0);
    set_in(1'b1, 8'h15, 1'b0, 8'h00);
    out_ready = 1'b1;
    step();
    set_in(1'b0, 8'h00, 1'b0, 8'h00);
    check_eq("fpop_ovf", 32'(overflow[0]), 32'd1);
    for (int k = 1; k < 5; k++) begin
      expect_out($sformatf("fpop_drain%0d", k), 8'(8'h10 + k), 1'b0);
      step();
    end
    check_eq("fpop_end_valid", 32'(out_valid), 32'd0);

    // Reset mid-stream (overflow[0] is still set from above); in_valid during rst is ignored.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 8'(8'h31 + i), 1'b0, 8'h00);
      step();
    end
    expect_out("mid_pre", 8'h31, 1'b0);
    set_in(1'b0, 8'h00, 1'b1, 8'h77);
    out_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_in(1'b0, 8'h00, 1'b0, 8'h00);
    check_eq("mid_valid", 32'(out_valid),   32'd0);
    check_eq("mid_data",  32'(out_data),    32'd0);
    check_eq("mid_ovf0",  32'(overflow[0]), 32'd0);
    check_eq("mid_ovf1",  32'(overflow[1]), 32'd0);
    step();
    step();
    check_eq("mid_flushed", 32'(out_valid), 32'd0);
    set_in(1'b1, 8'h5A, 1'b0, 8'h00);
    step();
    check_eq("mid_c1_valid", 32'(out_valid), 32'd0);
    set_in(1'b0, 8'h00, 1'b0, 8'h00);
    step();
    expect_out("mid_c2", 8'h5A, 1'b0);
    step();
    check_eq("mid_c3_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
